// File: rtl/multicycle_controller.sv
// Control unit for the RV32I multicycle core: Moore main FSM plus ALU and immediate decoders.
// Drives every datapath enable, mux select and the ALU operation from the state and instruction fields.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_t     state;
    state_t     next_state;
    state_t     eff_state;
    logic       pc_update;
    logic       branch;
    logic       take;
    logic [1:0] alu_op;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;
    logic       illegal_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= state_t'(RESET_STATE);
        else
            state <= next_state;
    end

    // While reset is held the selects follow FETCH; the enables are gated separately below.
    always_comb begin
        eff_state     = reset ? FETCH : state;
        next_state    = FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        illegal_raw   = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (eff_state)
            FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
                next_state   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BR:        next_state = BRANCH;
                    default: begin
                        next_state  = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            BRANCH: begin
                ALUSrcA  = 2'b10;
                alu_op   = 2'b01;
                branch   = 1'b1;
                done_raw = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  take = Zero;
            3'b001:  take = ~Zero;
            default: take = 1'b0;
        endcase
    end

    assign PCWrite       = ~reset & (pc_update | (branch & take));
    assign MemWrite      = ~reset & mem_write_raw;
    assign IRWrite       = ~reset & ir_write_raw;
    assign RegWrite      = ~reset & reg_write_raw;
    assign instr_done    = ~reset & done_raw;
    assign illegal_instr = ~reset & illegal_raw;

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 3'b000;
            OP_SW:       ImmSrc = 3'b001;
            OP_BR:       ImmSrc = 3'b010;
            OP_JAL:      ImmSrc = 3'b011;
            default:     ImmSrc = 3'b000;
        endcase
    end

    // Only the R-type form (op[5] set) turns funct3 000 into a subtract.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the expected per-cycle control
// words of each instruction, and a negedge monitor pops and compares them.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_XOR = 3'b100;
    localparam logic [2:0] A_SLT = 3'b101;

    typedef struct {
        logic [18:0] word;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done;
    logic       illegal_instr;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, done, ill};
    endfunction

    function automatic exp_t mk(input logic [18:0] w, input string n);
        exp_t e;
        e.word = w;
        e.name = n;
        return e;
    endfunction

    function automatic logic [2:0] model_imm(input logic [6:0] o);
        if (o == OP_SW)  return 3'b001;
        if (o == OP_BR)  return 3'b010;
        if (o == OP_JAL) return 3'b011;
        return 3'b000;
    endfunction

    // The arithmetic an R/I instruction asks for, by mnemonic.
    function automatic logic [2:0] model_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? A_SUB : A_ADD;
            3'b010:  return A_SLT;
            3'b100:  return A_XOR;
            3'b110:  return A_OR;
            3'b111:  return A_AND;
            default: return A_ADD;
        endcase
    endfunction

    task automatic build_sequence(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic z, input int max_cycles, output int n);
        exp_t       s[$];
        logic [2:0] imm;
        logic [2:0] fn;
        logic       take;
        logic       ill;
        imm  = model_imm(o);
        fn   = model_alu(o, f3, f7);
        take = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
        ill  = !(o inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR});
        s.push_back(mk(cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, A_ADD, 0, 0), "fetch"));
        s.push_back(mk(cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, A_ADD, 0, ill), "decode"));
        case (o)
            OP_LW: begin
                s.push_back(mk(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, A_ADD, 0, 0), "lw_memadr"));
                s.push_back(mk(cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, A_ADD, 0, 0), "lw_memread"));
                s.push_back(mk(cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, A_ADD, 1, 0), "lw_memwb"));
            end
            OP_SW: begin
                s.push_back(mk(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, A_ADD, 0, 0), "sw_memadr"));
                s.push_back(mk(cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1, 0), "sw_memwrite"));
            end
            OP_R: begin
                s.push_back(mk(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, fn, 0, 0), "r_execute"));
                s.push_back(mk(cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1, 0), "r_aluwb"));
            end
            OP_I: begin
                s.push_back(mk(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, fn, 0, 0), "i_execute"));
                s.push_back(mk(cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1, 0), "i_aluwb"));
            end
            OP_JAL: begin
                s.push_back(mk(cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, A_ADD, 0, 0), "jal"));
                s.push_back(mk(cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, A_ADD, 1, 0), "jal_aluwb"));
            end
            OP_BR: begin
                s.push_back(mk(cw(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, A_SUB, 1, 0), "branch"));
            end
            default: ;
        endcase
        n = 0;
        for (int i = 0; i < s.size() && i < max_cycles; i++) begin
            exp_q.push_back(s[i]);
            n++;
        end
    endtask

    // Called just after a rising edge with the FSM sitting in FETCH.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int max_cycles);
        int n;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        build_sequence(o, f3, f7, z, max_cycles, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++)
            exp_q.push_back(mk(cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, model_imm(op), A_ADD, 0, 0), "reset"));
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [18:0] got;
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, instr_done, illegal_instr};
        checks++;
        if (got !== e.word) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %019b expected %019b (pcw adr mw irw rw rs sa sb imm alu done ill)",
                     e.name, $time, got, e.word);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            checkOutput(exp_q.pop_front());
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [6:0] bad_ops [6];
        logic [6:0] o;
        bad_ops[0] = 7'b0110111;
        bad_ops[1] = 7'b0010111;
        bad_ops[2] = 7'b1100111;
        bad_ops[3] = 7'b1111111;
        bad_ops[4] = 7'b0000000;
        bad_ops[5] = 7'b1110011;

        reset    = 1'b1;
        op       = 7'd0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        @(posedge clk);
        #1;
        applyReset(3);

        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 99);
        applyStimulus(OP_R,  3'b000, 1'b1, 1'b0, 99);
        applyStimulus(OP_R,  3'b000, 1'b0, 1'b0, 99);
        applyStimulus(OP_I,  3'b000, 1'b1, 1'b0, 99);
        applyStimulus(OP_BR, 3'b000, 1'b0, 1'b1, 99);
        applyStimulus(OP_BR, 3'b001, 1'b0, 1'b1, 99);
        applyStimulus(OP_BR, 3'b001, 1'b0, 1'b0, 99);
        applyStimulus(OP_BR, 3'b100, 1'b0, 1'b1, 99);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 99);
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 99);
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 99);

        // lw cut off in MEMREAD by a reset, then a clean lw afterwards.
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 3);
        applyReset(2);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 99);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 7))
                0:       o = OP_LW;
                1:       o = OP_SW;
                2:       o = OP_R;
                3:       o = OP_I;
                4:       o = OP_JAL;
                5:       o = OP_BR;
                6:       o = bad_ops[$urandom_range(0, 5)];
                default: o = 7'($urandom);
            endcase
            applyStimulus(o, 3'($urandom), 1'($urandom), 1'($urandom), 99);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
